// File: rtl/seek_z.sv
// Iterative shift-add multiplier: z = a * b (unsigned, exact), STEP multiplier bits per cycle.
// Optional early exit on an exhausted multiplier when SEEK_Z_EARLY_EXIT_EN is defined.
module seek_z #(
  parameter int WIDTH = 33,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic [2*WIDTH-1:0] z,
  output logic               rdy
);

  // state | meaning
  // IDLE  | waiting for en; z holds the last result
  // BUSY  | one STEP-bit partial product accumulated per cycle
  // DONE  | single cycle with rdy high and z valid
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int ZW = 2 * WIDTH;
  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);

  state_t            state, state_nxt;
  logic [ZW-1:0]     acc, acc_nxt;
  logic [ZW-1:0]     mcand, mcand_nxt;
  logic [ZW-1:0]     z_nxt;
  logic [ZW-1:0]     partial;
  logic [WIDTH-1:0]  mplier, mplier_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      z      <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      cnt    <= cnt_nxt;
      z      <= z_nxt;
    end
  end

  // mcand is pre-shifted each step, so the partial product needs no variable shift.
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    cnt_nxt    = cnt;
    z_nxt      = z;
    partial    = mcand * ZW'(mplier[STEP-1:0]);
    last       = (cnt == '0);
`ifdef SEEK_Z_EARLY_EXIT_EN
    last       = last || ((mplier >> STEP) == '0);
`endif
    case (state)
      IDLE: begin
        if (en) begin
          mcand_nxt  = ZW'(a);
          mplier_nxt = b;
          acc_nxt    = '0;
          cnt_nxt    = CW'(N - 1);
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        acc_nxt    = acc + partial;
        mcand_nxt  = mcand << STEP;
        mplier_nxt = mplier >> STEP;
        cnt_nxt    = cnt - CW'(1);
        if (last) begin
          z_nxt     = acc + partial;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign rdy  = (state == DONE);

endmodule

// File: tb/tb_seek_z.sv
// Bench for seek_z: STEP=1 and STEP=3 instances share stimulus; a cycle-count model
// predicts busy/rdy/z every cycle, plus literal latency and product checks.
module tb_seek_z;

`ifdef SEEK_Z_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int W = 33;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [W-1:0]  a, b;
  logic [1:0]    busy_w, rdy_w;
  logic [2*W-1:0] z0, z1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  seek_z #(.WIDTH(W), .STEP(1)) dut0 (
    .clk(clk), .reset(reset), .en(en), .a(a), .b(b),
    .busy(busy_w[0]), .z(z0), .rdy(rdy_w[0]));

  seek_z #(.WIDTH(W), .STEP(3)) dut1 (
    .clk(clk), .reset(reset), .en(en), .a(a), .b(b),
    .busy(busy_w[1]), .z(z1), .rdy(rdy_w[1]));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Cycles from acceptance to the edge that raises rdy.
  function automatic int lat_of(input logic [W-1:0] bv, input int step);
    int msb;
    if (!EARLY) return W / step;
    if (bv == '0) return 1;
    msb = 0;
    for (int i = 0; i < W; i++) if (bv[i]) msb = i;
    return (msb + step) / step;
  endfunction

  bit             m_act  [2] = '{0, 0};
  int             m_t    [2] = '{0, 0};
  int             m_lat  [2] = '{0, 0};
  logic [2*W-1:0] m_prod [2] = '{0, 0};
  logic [2*W-1:0] m_z    [2] = '{0, 0};
  int             steps  [2] = '{1, 3};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 1'b0;
        m_z[i]   = '0;
      end
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (m_act[i] && (cyc - m_t[i] == m_lat[i])) m_z[i] = m_prod[i];
        if ((!m_act[i] || cyc >= m_t[i] + m_lat[i] + 2) && en) begin
          m_act[i]  = 1'b1;
          m_t[i]    = cyc;
          m_lat[i]  = lat_of(b, steps[i]);
          m_prod[i] = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int d;
      d = cyc - m_t[i];
      chk($sformatf("busy%0d", i), {65'b0, busy_w[i]}, {65'b0, m_act[i] && d >= 0 && d <= m_lat[i]});
      chk($sformatf("rdy%0d", i),  {65'b0, rdy_w[i]},  {65'b0, m_act[i] && d == m_lat[i]});
      chk($sformatf("z%0d", i), (i == 0) ? z0 : z1, m_z[i]);
    end
  end

  task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv, output int k);
    @(posedge clk); #2;
    a = av; b = bv; en = 1'b1;
    @(posedge clk); #2;
    k = cyc;
    en = 1'b0;
  endtask

  task automatic wait_rdy(input int which, input int k, input int exp_n, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (rdy_w[which]) seen = 1'b1;
    end
    if (!seen) chk({nm, "_timeout"}, 66'd0, 66'd1);
    else       chk(nm, 66'(cyc - k), 66'(exp_n));
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      if (busy_w == 2'b00) idle = 1'b1;
    end
    if (!idle) chk("idle_timeout", 66'd0, 66'd1);
  endtask

  initial begin
    int k;
    reset = 1'b0; en = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    repeat (10) begin
      @(negedge clk);
      chk("idle_z0", z0, 66'd0);
      chk("idle_busy", {64'b0, busy_w}, 66'd0);
    end

    start(33'd5, 33'd7, k);
    wait_rdy(1, k, EARLY ? 1 : 11, "lat1_5x7");
    chk("z1_5x7", z1, 66'd35);
    wait_rdy(0, k, EARLY ? 3 : 33, "lat0_5x7");
    chk("z0_5x7", z0, 66'd35);
    wait_idle();
    repeat (4) @(negedge clk);
    chk("z0_hold", z0, 66'd35);

    start({W{1'b1}}, {W{1'b1}}, k);
    wait_rdy(1, k, 11, "lat1_max");
    chk("z1_max", z1, 66'h3_FFFF_FFFC_0000_0001);
    wait_rdy(0, k, 33, "lat0_max");
    chk("z0_max", z0, 66'h3_FFFF_FFFC_0000_0001);
    wait_idle();

    start(33'd100, 33'd200, k);
    @(posedge clk); #2;
    a = 33'd1; b = 33'd1; en = 1'b1;
    @(posedge clk); #2;
    en = 1'b0; a = 33'd77; b = 33'd99;
    wait_rdy(0, k, EARLY ? 8 : 33, "lat0_ignore");
    chk("z0_ignore", z0, 66'd20000);
    chk("z1_ignore", z1, 66'd20000);
    a = 33'd6; b = 33'd7; en = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    en = 1'b0;
    wait_idle();
    chk("z0_6x7", z0, 66'd42);
    chk("z1_6x7", z1, 66'd42);

    start(33'd11, 33'd1 << 30, k);
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", {64'b0, busy_w}, 66'd0);
    chk("rst_rdy", {64'b0, rdy_w}, 66'd0);
    chk("rst_z0", z0, 66'd0);
    @(posedge clk); #2 reset = 1'b1;

    start(33'd3, 33'd4, k);
    wait_rdy(0, k, EARLY ? 3 : 33, "lat0_3x4");
    chk("z0_3x4", z0, 66'd12);
    wait_idle();

    start(33'd9, 33'd1, k);
    wait_rdy(0, k, EARLY ? 1 : 33, "lat0_9x1");
    chk("z0_9x1", z0, 66'd9);
    wait_idle();

    start(33'd9, 33'd0, k);
    wait_rdy(0, k, EARLY ? 1 : 33, "lat0_9x0");
    chk("z0_9x0", z0, 66'd0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seek_z.md
Name: seek_z

Overview:
- Iterative shift-add multiplier. Produces the double-width product z consumed by seek_r in the modular-reduction datapath.
- Operands a, b are reduced residues, each `Datawidth+1 bits wide.
- Output z is 2*`Datawidth+2 bits. seek_r takes its low part, z[32:0].
- Uses the same en/rdy handshake style as seek_r, so rdy can drive seek_r's en directly.

Parameters:
- WIDTH, `Datawidth+1 (33): operand width. z width is 2*WIDTH.
- STEP, 1: multiplier bits consumed per cycle. Must divide WIDTH (legal values 1, 3, 11, 33). N = WIDTH/STEP compute cycles.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  start request. Sampled only in IDLE.
- a  input  WIDTH  multiplicand. Captured when en is accepted.
- b  input  WIDTH  multiplier. Captured when en is accepted.
- busy  output  1  high in BUSY and DONE.
- z  output  2*WIDTH  product a*b, unsigned, exact (no truncation).
- rdy  output  1  one-cycle pulse; z is valid while high.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - busy=0, rdy=0, z=0.
  - Internal accumulator, operand registers and counter are cleared.
- Reset asserted mid-operation aborts the operation with no rdy pulse. After release, the next en starts a fresh operation.
- IDLE:
  - en=1 at edge k: latch a into mcand, b into mplier; acc=0; cnt=0; go to BUSY. busy=1 from edge k.
  - en=0: stay in IDLE; z holds its last result.
- BUSY, each cycle:
  - acc += (mcand * mplier[STEP-1:0]) << (cnt*STEP).
  - mplier >>= STEP; cnt++.
  - After the N-th step (edge k+N): z <= final acc, rdy <= 1, go to DONE.
- DONE: lasts exactly one cycle. At edge k+N+1: rdy <= 0, busy <= 0, go to IDLE.
- Latency: rdy is high in the cycle after edge k+N. With defaults (STEP=1) that is edge k+33.
- Start throughput: one start per N+2 cycles.
- en while busy=1 (BUSY or DONE): ignored; no queuing.
- a/b changing after acceptance: no effect on the current result.
- z updates only on the edge that raises rdy. It holds its value through IDLE until the next result, so seek_r may sample z on rdy or later.
- Arithmetic: unsigned. Accumulator is 2*WIDTH bits and never overflows, since max product (2^WIDTH-1)^2 < 2^(2*WIDTH). No modular reduction is done here; that is seek_r's job.
- Zero operands use normal timing (full N cycles) unless the optional feature is enabled.

Optional Feature:
- Macro: SEEK_Z_EARLY_EXIT_EN.
- Defined:
  - In BUSY, if the remaining shifted mplier == 0 after a step, go to DONE on that edge.
  - If b == 0 at acceptance, go to DONE after exactly 1 BUSY cycle.
  - Latency becomes ceil((msb_index(b)+1)/STEP) cycles, minimum 1.
  - The z result is identical to the full computation.
- Undefined: fixed latency N for all operands; the early-exit logic is absent.

Test Plan:
- Reset release, idle with en=0 for 10 cycles -> busy=0, rdy=0, z=0 throughout.
- a=5, b=7, en pulse at edge k (STEP=1) -> rdy=1 for exactly one cycle after edge k+33; z=35 then, and held until the next start.
- a=b=2^33-1 -> z=2^66-2^34+1 (0x3_FFFF_FFFC_0000_0001). Repeat with STEP=3 -> same z, rdy after edge k+11.
- Second en pulse and a change of a, b during BUSY -> ignored; result still matches the first operands; next start accepted only in IDLE.
- Assert reset at edge k+10 of an operation -> busy=0, rdy=0, z=0 immediately with no rdy pulse. New start a=3, b=4 -> z=12 after 33 cycles.
- With SEEK_Z_EARLY_EXIT_EN: b=1, a=9 -> rdy after edge k+1, z=9; b=0 -> rdy after edge k+1, z=0. Without the macro: both take 33 cycles.
